// File: rtl/sysa_sequencer.sv
// Purpose: sequences one 3x3 systolic-array job (weight load, skewed feed, drain, result capture).
// Latency: start in cycle 0 -> done in cycle 12+PIPE_LAT when in_valid is held high.
// Backpressure: each missing in_valid in LOAD_W/LOAD_I stalls the job one cycle; in_ready is state-decoded only.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, busy, done     job control / status (done is a one-cycle pulse)
//   in_valid/ready/data   32-bit operand stream, bytes [23:0] used
//   sa_w, sa_en, sa_in    array weight-load strobe, compute enable, lane data
//   sa_out1..3            array column results
//   res_idx, res_data     registered read of the 9-entry result buffer
module sysa_sequencer #(
   parameter int PIPE_LAT = 3,
   parameter int OW       = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          busy,
   output logic          done,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_data,
   output logic          sa_w,
   output logic          sa_en,
   output logic [23:0]   sa_in,
   input  logic [OW-1:0] sa_out1,
   input  logic [OW-1:0] sa_out2,
   input  logic [OW-1:0] sa_out3,
   input  logic [3:0]    res_idx,
   output logic [OW-1:0] res_data
);

   // k counts cycles from the first FEED cycle; the last capture happens at k = 4+PIPE_LAT.
   localparam int KMAX = 4 + PIPE_LAT;
   localparam int KW   = $clog2(KMAX + 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_LOAD_I,
      S_FEED,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      wcnt_q, wcnt_d;
   logic [KW-1:0]   k_q, k_d;
   logic [3:0]      cap_q, cap_d;
   logic [23:0]     x_q [3];
   logic [23:0]     w_q;
   logic            w_vld_q;
   logic [OW-1:0]   res_q [9];
   logic [OW-1:0]   sa_col [3];
   logic            accept;
   logic            cap_en;
   logic [2:0]      cap_hit;
   logic [3:0]      ncap;
   logic [23:0]     feed_lanes;
   int              k_int;

   assign sa_col[0] = sa_out1;
   assign sa_col[1] = sa_out2;
   assign sa_col[2] = sa_out3;

   assign k_int    = int'(k_q);
   assign in_ready = (state_q == S_LOAD_W) || (state_q == S_LOAD_I);
   assign accept   = in_ready && in_valid;
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign sa_en    = (state_q == S_FEED) || (state_q == S_DRAIN);
   assign cap_en   = sa_en;
   assign sa_w     = w_vld_q;
   // Weight words are replayed one cycle after acceptance; otherwise the skewed feed (zero outside FEED).
   assign sa_in    = w_vld_q ? w_q : feed_lanes;

   // Diagonal skew: lane j carries row (k-j) of the input matrix during FEED.
   always_comb begin
      feed_lanes = '0;
      for (int j = 0; j < 3; j++) begin
         for (int r = 0; r < 3; r++) begin
            if (state_q == S_FEED && k_int == r + j) begin
               feed_lanes[8*j +: 8] = x_q[r][8*j +: 8];
            end
         end
      end
   end

   // Lane j holds a valid result for row r at k = r + j + PIPE_LAT; up to three lanes capture per cycle.
   always_comb begin
      cap_hit = '0;
      for (int j = 0; j < 3; j++) begin
         for (int r = 0; r < 3; r++) begin
            if (cap_en && k_int == r + j + PIPE_LAT) begin
               cap_hit[j] = 1'b1;
            end
         end
      end
      ncap = 4'(cap_hit[0]) + 4'(cap_hit[1]) + 4'(cap_hit[2]);
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      k_d     = k_q;
      cap_d   = cap_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD_W;
               wcnt_d  = '0;
               k_d     = '0;
               cap_d   = '0;
            end
         end
         S_LOAD_W: begin
            if (accept) begin
               if (wcnt_q == 2'd2) begin
                  wcnt_d  = '0;
                  state_d = S_LOAD_I;
               end else begin
                  wcnt_d = wcnt_q + 2'd1;
               end
            end
         end
         S_LOAD_I: begin
            if (accept) begin
               if (wcnt_q == 2'd2) begin
                  wcnt_d  = '0;
                  k_d     = '0;
                  state_d = S_FEED;
               end else begin
                  wcnt_d = wcnt_q + 2'd1;
               end
            end
         end
         S_FEED: begin
            k_d   = k_q + KW'(1);
            cap_d = cap_q + ncap;
            if (k_q == KW'(4)) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            k_d   = k_q + KW'(1);
            cap_d = cap_q + ncap;
            if (cap_q + ncap == 4'd9) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wcnt_q   <= '0;
         k_q      <= '0;
         cap_q    <= '0;
         w_q      <= '0;
         w_vld_q  <= 1'b0;
         res_data <= '0;
         for (int r = 0; r < 3; r++) begin
            x_q[r] <= '0;
         end
         for (int n = 0; n < 9; n++) begin
            res_q[n] <= '0;
         end
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         k_q     <= k_d;
         cap_q   <= cap_d;
         w_vld_q <= (state_q == S_LOAD_W) && accept;
         if ((state_q == S_LOAD_W) && accept) begin
            w_q <= in_data[23:0];
         end
         if ((state_q == S_LOAD_I) && accept) begin
            x_q[wcnt_q] <= in_data[23:0];
         end
         if ((state_q == S_IDLE) && start) begin
            for (int n = 0; n < 9; n++) begin
               res_q[n] <= '0;
            end
         end else begin
            for (int j = 0; j < 3; j++) begin
               for (int r = 0; r < 3; r++) begin
                  if (cap_hit[j] && k_int == r + j + PIPE_LAT) begin
                     res_q[3*r + j] <= sa_col[j];
                  end
               end
            end
         end
         res_data <= (res_idx <= 4'd8) ? res_q[res_idx] : '0;
      end
   end

endmodule

// File: tb/tb_sysa_sequencer.sv
module tb_sysa_sequencer;

   localparam int OW = 16;

   logic          clk = 1'b0;
   logic          rst_n, start, in_valid;
   logic [31:0]   in_data;
   logic [3:0]    res_idx;
   logic          busy [2];
   logic          done [2];
   logic          in_ready [2];
   logic          sa_w [2];
   logic          sa_en [2];
   logic [23:0]   sa_in [2];
   logic [OW-1:0] res_data [2];
   logic [OW-1:0] aout [2][3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sysa_sequencer #(.PIPE_LAT(3), .OW(OW)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[0]), .done(done[0]),
      .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
      .sa_w(sa_w[0]), .sa_en(sa_en[0]), .sa_in(sa_in[0]),
      .sa_out1(aout[0][0]), .sa_out2(aout[0][1]), .sa_out3(aout[0][2]),
      .res_idx(res_idx), .res_data(res_data[0])
   );

   sysa_sequencer #(.PIPE_LAT(1), .OW(OW)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[1]), .done(done[1]),
      .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
      .sa_w(sa_w[1]), .sa_en(sa_en[1]), .sa_in(sa_in[1]),
      .sa_out1(aout[1][0]), .sa_out2(aout[1][1]), .sa_out3(aout[1][2]),
      .res_idx(res_idx), .res_data(res_data[1])
   );

   function automatic int pl_of(input int i);
      return (i == 0) ? 3 : 1;
   endfunction

   // Array model: weight rows latched on sa_w; lane history recorded per enabled cycle.
   // Column j for input row r emerges PIPE_LAT cycles after operand x[r][j] entered lane j,
   // as the partial sum over lanes 0..j of W[j][k]*x[r][k].
   logic [23:0] wt [2][3];
   logic [23:0] hist [2][32];
   int          wrow [2] = '{0, 0};
   int          ecnt [2] = '{0, 0};
   int          acc_m, idx_m;

   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (sa_w[i]) begin
            wt[i][wrow[i]] <= sa_in[i];
            wrow[i]        <= (wrow[i] == 2) ? 0 : wrow[i] + 1;
         end
         if (sa_en[i]) begin
            hist[i][ecnt[i][4:0]] <= sa_in[i];
            ecnt[i]               <= ecnt[i] + 1;
         end else begin
            ecnt[i] <= 0;
         end
      end
   end

   always_comb begin
      acc_m = 0;
      idx_m = 0;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 3; j++) begin
            acc_m = 0;
            for (int k = 0; k <= j; k++) begin
               idx_m = ecnt[i] - j - pl_of(i) + k;
               if (idx_m >= 0 && idx_m < 32) begin
                  acc_m = acc_m + int'(wt[i][j][8*k +: 8]) * int'(hist[i][idx_m[4:0]][8*k +: 8]);
               end
            end
            aout[i][j] = acc_m[OW-1:0];
         end
      end
   end

   logic [23:0] job_w [3];
   logic [23:0] job_x [3];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
      end
   endtask

   // mode 0: in_valid held high; 1: in_valid high on even cycles only; 2: as 0 plus stray starts.
   // rst_cyc >= 0 asserts reset in that cycle and ends the job after checking the reset state.
   task automatic run_job(input int mode, input int rst_cyc);
      int          acc_c [6];
      int          feed;
      int          done_c [2];
      int          ndone [2];
      logic [15:0] exp_r [9];
      logic [31:0] e;
      logic [31:0] word;
      bit          hit;

      for (int n = 0; n < 6; n++) begin
         acc_c[n] = (mode == 1) ? 2 + 2*n : 1 + n;
      end
      feed = acc_c[5] + 1;
      for (int i = 0; i < 2; i++) begin
         done_c[i] = feed + 5 + pl_of(i);
         ndone[i]  = 0;
      end
      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j < 3; j++) begin
            e = 0;
            for (int k = 0; k <= j; k++) begin
               e = e + 32'(job_w[j][8*k +: 8]) * 32'(job_x[r][8*k +: 8]);
            end
            exp_r[3*r + j] = e[15:0];
         end
      end

      for (int c = 0; c <= done_c[0] + 2; c++) begin
         if (rst_cyc >= 0 && c == rst_cyc + 1) begin
            for (int i = 0; i < 2; i++) begin
               chk("rst_busy", i, 32'(busy[i]), 32'd0);
               chk("rst_done", i, 32'(done[i]), 32'd0);
               chk("rst_in_ready", i, 32'(in_ready[i]), 32'd0);
               chk("rst_sa_w", i, 32'(sa_w[i]), 32'd0);
               chk("rst_sa_en", i, 32'(sa_en[i]), 32'd0);
               chk("rst_sa_in", i, 32'(sa_in[i]), 32'd0);
               chk("rst_res_data", i, 32'(res_data[i]), 32'd0);
            end
            rst_n    = 1'b1;
            start    = 1'b0;
            in_valid = 1'b0;
            for (int n = 0; n < 9; n++) begin
               res_idx = 4'(n);
               tick();
               for (int i = 0; i < 2; i++) begin
                  chk("rst_buf", n, 32'(res_data[i]), 32'd0);
               end
            end
            return;
         end

         for (int i = 0; i < 2; i++) begin
            chk("in_ready", c, 32'(in_ready[i]), 32'(c >= 1 && c <= acc_c[5]));
            chk("sa_w", c, 32'(sa_w[i]),
                32'(c == acc_c[0] + 1 || c == acc_c[1] + 1 || c == acc_c[2] + 1));
            chk("sa_en", c, 32'(sa_en[i]), 32'(c >= feed && c < done_c[i]));
            chk("done", c, 32'(done[i]), 32'(c == done_c[i]));
            chk("busy", c, 32'(busy[i]), 32'(c >= 1 && c <= done_c[i]));
            chk("w_en_excl", c, 32'(sa_w[i] & sa_en[i]), 32'd0);
            if (c == 5) chk("read_busy", i, 32'(res_data[i]), 32'd0);
            ndone[i] += int'(done[i]);
         end

         start    = (c == 0) || (mode == 2 && (c == 3 || c == 9));
         in_valid = (mode == 1) ? (c % 2 == 0) : 1'b1;
         res_idx  = 4'd4;
         hit      = 1'b0;
         word     = $urandom;
         for (int n = 0; n < 6; n++) begin
            if (acc_c[n] == c) begin
               hit  = 1'b1;
               word = {8'($urandom), (n < 3) ? job_w[n] : job_x[n-3]};
            end
         end
         in_data = word;
         if (!hit && in_valid && c >= 1 && c <= acc_c[5]) begin
            $fatal(1, "FAIL stimulus schedule inconsistent at cycle %0d", c);
         end
         if (c == rst_cyc) rst_n = 1'b0;
         tick();
      end

      start    = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("done_count", i, 32'(ndone[i]), 32'd1);
      end
      for (int n = 0; n < 16; n++) begin
         res_idx = 4'(n);
         tick();
         for (int i = 0; i < 2; i++) begin
            chk("result", n, 32'(res_data[i]), (n < 9) ? 32'(exp_r[n]) : 32'd0);
         end
      end
   endtask

   task automatic random_job();
      for (int n = 0; n < 3; n++) begin
         job_w[n] = 24'($urandom);
         job_x[n] = 24'($urandom);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      res_idx  = '0;
      repeat (3) tick();
      for (int i = 0; i < 2; i++) begin
         chk("reset_busy", i, 32'(busy[i]), 32'd0);
         chk("reset_done", i, 32'(done[i]), 32'd0);
         chk("reset_in_ready", i, 32'(in_ready[i]), 32'd0);
         chk("reset_sa_w", i, 32'(sa_w[i]), 32'd0);
         chk("reset_sa_en", i, 32'(sa_en[i]), 32'd0);
         chk("reset_sa_in", i, 32'(sa_in[i]), 32'd0);
         chk("reset_res_data", i, 32'(res_data[i]), 32'd0);
      end
      rst_n = 1'b1;
      tick();

      // Identity weights: results read back as 1..9.
      job_w[0] = 24'h000001; job_w[1] = 24'h000100; job_w[2] = 24'h010000;
      job_x[0] = 24'h030201; job_x[1] = 24'h060504; job_x[2] = 24'h090807;
      run_job(0, -1);

      random_job();
      run_job(1, -1);

      random_job();
      run_job(2, -1);

      random_job();
      run_job(0, 9);

      random_job();
      run_job(0, -1);

      random_job();
      run_job(1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sysa_sequencer.md
# sysa_sequencer

Sequencer for the 3x3 8-bit systolic array (`sysa`). It accepts one job: three weight rows and three input rows, delivered as 32-bit words over a valid/ready stream. It drives the array's load/enable/input lanes with the diagonal skew, captures the nine 16-bit results into a local buffer, and signals completion. It sits between the Wishbone/FIFO front end and `sysa`, replacing the ad-hoc load/run FSMs in the top level.

## Interface
Parameters:
- `PIPE_LAT`, default 3: cycles from a lane's last relevant operand to its valid output (≥1).
- `OW`, default 16: result width.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  job start; sampled only in IDLE.
- `busy`  out  1  high from the cycle after an accepted start through the DONE cycle.
- `done`  out  1  one-cycle pulse in DONE.
- `in_valid`  in  1  stream word valid.
- `in_ready`  out  1  high in LOAD_W and LOAD_I only.
- `in_data`  in  32  stream word; [23:0] = three bytes, byte c in [8c+7:8c]; [31:24] ignored.
- `sa_w`  out  1  weight-load strobe to array.
- `sa_en`  out  1  array compute enable.
- `sa_in`  out  24  array lane data; lane j = [8j+7:8j].
- `sa_out1`, `sa_out2`, `sa_out3`  in  OW each  array column outputs (lane j ↔ `sa_out{j+1}`).
- `res_idx`  in  4  result index 0..8.
- `res_data`  out  OW  registered result read.

## Operation
- States: IDLE → LOAD_W → LOAD_I → FEED → DRAIN → DONE → IDLE.
- IDLE: `in_ready`=0. On `start`=1, clear the result buffer and go to LOAD_W.
- LOAD_W: accept 3 words (handshake = `in_valid & in_ready`). The cycle after each accept, `sa_w`=1 and `sa_in`=word[23:0]; otherwise `sa_w`=0. After the 3rd accept, go to LOAD_I.
- LOAD_I: accept 3 words into row registers x[r], r=0..2, element x[r][c]=byte c. After the 3rd accept, go to FEED.
- FEED: 5 cycles, t=0..4, first cycle F. Lane j = x[t−j][j] if 0≤t−j≤2, else 0. `sa_en`=1.
- DRAIN: `sa_en`=1, `sa_in`=0. Stay until all 9 captures are done.
- Capture: in FEED/DRAIN, at the clock edge ending cycle F+r+j+PIPE_LAT, store `sa_out{j+1}` into result[3r+j]. A 4-bit capture counter counts to 9.
- DONE: `done`=1 for one cycle, then IDLE. Results are held until the next accepted start.
- `start` outside IDLE is ignored. `in_valid` outside the LOAD states is ignored and not consumed.
- Result read: `res_data` = result[`res_idx`] one cycle after `res_idx` is presented. Reads are allowed in any state. `res_idx`>8 returns 0.
- Reset (`rst_n`=0 at a clock edge, any state): state→IDLE, all counters and row registers 0, result buffer 0.

## Timing
- Reset values: `busy`, `done`, `in_ready`, `sa_w`, `sa_en` = 0; `sa_in` = 0; `res_data` = 0.
- With `start` in cycle 0 and `in_valid` held high:
  - `in_ready` is high cycles 1–6.
  - `sa_w` is high cycles 2–4.
  - FEED is cycles 7–11.
  - DRAIN is cycles 12..11+PIPE_LAT; last capture at the end of cycle 11+PIPE_LAT.
  - `done` is in cycle 12+PIPE_LAT; `busy` falls the following cycle.
- Backpressure: each `in_valid` gap stalls the FSM one cycle. There is no combinational path from `in_valid` to `in_ready`.
- `sa_w` and `sa_en` are never high together.
- Reset has priority over all events in the same cycle.

## Test plan
- Identity weights, x rows 0x030201/0x060504/0x090807, PIPE_LAT=3, model array with out = W·x → `done` in cycle 15; results[0..8] = 1..9 read back via `res_idx` with 1-cycle latency.
- `in_valid` toggled 1/0 every cycle → same results; `done` delayed by exactly 6 cycles; no word dropped or duplicated.
- `start` pulsed in cycles 3 and 9 of a job → ignored; job completes normally; exactly one `done`.
- `rst_n` low in FEED cycle 9 → next cycle IDLE, `busy`=0, all outputs 0, `res_data` reads 0; a new job then completes correctly.
- `res_idx`=9..15 → `res_data`=0. Read of index 4 while `busy` → returns 0 (buffer cleared at start).
- PIPE_LAT=1 build → `done` in cycle 13; captured values correct.
